// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per cycle.
// Ports: clk, reset, start, dividend, divisor -> quotient, remainder, busy, done, div_by_zero.
module restoring_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state_q, state_d;

  // The partial remainder is always below the divisor between steps,
  // so WIDTH bits hold it; only the trial difference needs WIDTH+1.
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] qw_q, qw_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] quo_d, rem_d;
  logic             dz_d;

  logic [WIDTH:0]   r_sh;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH:0]   trial;

  assign r_sh  = {r_q, qw_q[WIDTH-1]};
  assign q_sh  = {qw_q[WIDTH-2:0], 1'b0};
  assign trial = r_sh - {1'b0, d_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      r_q         <= '0;
      qw_q        <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      qw_q        <= qw_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      quotient    <= quo_d;
      remainder   <= rem_d;
      div_by_zero <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    qw_d    = qw_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quo_d   = quotient;
    rem_d   = remainder;
    dz_d    = div_by_zero;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          if (divisor == '0) begin
            state_d = DONE;
            quo_d   = '1;
            rem_d   = dividend;
            dz_d    = 1'b1;
          end else begin
            state_d = CALC;
            r_d     = '0;
            qw_d    = dividend;
            d_d     = divisor;
            cnt_d   = CW'(WIDTH);
          end
        end
      end
      CALC: begin
        if (!trial[WIDTH]) begin
          r_d  = trial[WIDTH-1:0];
          qw_d = q_sh | WIDTH'(1);
        end else begin
          r_d  = r_sh[WIDTH-1:0];
          qw_d = q_sh;
        end
        cnt_d = cnt_q - CW'(1);
        // Final bit resolved this cycle: publish straight from next values.
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          quo_d   = qw_d;
          rem_d   = r_d;
          dz_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == CALC);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider (WIDTH = 16).
// Scoreboard of expected results, popped on every done pulse.
module tb_restoring_divider;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int checks;
  int errors;

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
  } exp_t;

  exp_t sb[$];

  restoring_divider #(.WIDTH(16)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .quotient(quotient),
    .remainder(remainder),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge: raise start and record the expected result.
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    if (b == 16'd0) e = '{16'hFFFF, a, 1'b1};
    else e = '{a / b, a % b, 1'b0};
    sb.push_back(e);
  endtask

  // Counts negedges from the issuing negedge until done is seen.
  task automatic wait_done(output int n, output bit busy_seen,
                           output bit tmo);
    n = 0;
    busy_seen = 1'b0;
    tmo = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
      if (busy) busy_seen = 1'b1;
      if (done) begin
        tmo = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({quotient, remainder, busy, done, div_by_zero} !== 35'd0) begin
      errors++;
      $display("FAIL reset_state: got q=%h r=%h b=%b d=%b z=%b, want all 0",
               quotient, remainder, busy, done, div_by_zero);
    end
  endtask

  task automatic test_basic();
    int n; bit bs, tmo; exp_t e;
    issue(16'd100, 16'd7);
    wait_done(n, bs, tmo);
    e = sb.pop_front();
    checks++;
    if (tmo || n != 17) begin
      errors++;
      $display("FAIL basic_latency: got %0d (timeout=%0b), want 17", n, tmo);
    end
    checks++;
    if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dz}) begin
      errors++;
      $display("FAIL basic_100_7: got q=%0d r=%0d z=%b, want q=%0d r=%0d z=%b",
               quotient, remainder, div_by_zero, e.q, e.r, e.dz);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_width: got done=%b, want 0", done);
    end
  endtask

  task automatic test_extremes();
    int n; bit bs, tmo; exp_t e;
    logic [15:0] av[2];
    logic [15:0] bv[2];
    av[0] = 16'hFFFF; bv[0] = 16'h0001;
    av[1] = 16'hFFFF; bv[1] = 16'hFFFF;
    for (int k = 0; k < 2; k++) begin
      issue(av[k], bv[k]);
      wait_done(n, bs, tmo);
      e = sb.pop_front();
      checks++;
      if (tmo || {quotient, remainder} !== {e.q, e.r}) begin
        errors++;
        $display("FAIL extremes_%0d: got q=%h r=%h, want q=%h r=%h",
                 k, quotient, remainder, e.q, e.r);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_div_zero();
    int n; bit bs, tmo; exp_t e;
    issue(16'd5, 16'd0);
    wait_done(n, bs, tmo);
    e = sb.pop_front();
    checks++;
    if (tmo || n != 1 || bs) begin
      errors++;
      $display("FAIL zero_timing: got n=%0d busy_seen=%b, want n=1 busy 0",
               n, bs);
    end
    checks++;
    if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dz}) begin
      errors++;
      $display("FAIL zero_result: got q=%h r=%0d z=%b, want q=%h r=%0d z=%b",
               quotient, remainder, div_by_zero, e.q, e.r, e.dz);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_busy();
    int n, extra; bit seen; exp_t e;
    issue(16'd3, 16'd10);
    @(negedge clk);
    start = 1'b0;
    n = 1;
    repeat (3) begin @(negedge clk); n++; end
    dividend = 16'd999;
    divisor  = 16'd1;
    start    = 1'b1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL ignore_busy_flag: got busy=%b, want 1", busy);
    end
    @(negedge clk);
    n++;
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) seen = 1'b1;
      else begin @(negedge clk); n++; end
    end
    e = sb.pop_front();
    checks++;
    if (!seen || n != 17 ||
        {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dz}) begin
      errors++;
      $display("FAIL ignore_busy: got n=%0d q=%0d r=%0d, want n=17 q=%0d r=%0d",
               n, quotient, remainder, e.q, e.r);
    end
    extra = 0;
    repeat (25) begin @(negedge clk); if (done) extra++; end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL ignore_extra_done: got %0d pulses, want 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    int n, extra; bit bs, tmo; exp_t e;
    issue(16'd1000, 16'd3);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({quotient, remainder, busy, done, div_by_zero} !== 35'd0) begin
      errors++;
      $display("FAIL reset_mid: got q=%h r=%h b=%b d=%b, want all 0",
               quotient, remainder, busy, done);
    end
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    extra = 0;
    repeat (25) begin @(negedge clk); if (done) extra++; end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL reset_no_done: got %0d pulses, want 0", extra);
    end
    issue(16'd1000, 16'd3);
    wait_done(n, bs, tmo);
    e = sb.pop_front();
    checks++;
    if (tmo || {quotient, remainder} !== {e.q, e.r}) begin
      errors++;
      $display("FAIL reset_redo: got q=%0d r=%0d, want q=%0d r=%0d",
               quotient, remainder, e.q, e.r);
    end
  endtask

  // Entered at the negedge of a done cycle.
  task automatic test_back_to_back();
    int n; bit bs, tmo; exp_t e;
    issue(16'd50, 16'd8);
    wait_done(n, bs, tmo);
    e = sb.pop_front();
    checks++;
    if (tmo || n != 17) begin
      errors++;
      $display("FAIL b2b_latency: got %0d, want 17", n);
    end
    checks++;
    if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dz}) begin
      errors++;
      $display("FAIL b2b_50_8: got q=%0d r=%0d, want q=%0d r=%0d",
               quotient, remainder, e.q, e.r);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int n; bit bs, tmo; exp_t e;
    logic [15:0] a, b;
    for (int k = 0; k < 2000; k++) begin
      a = 16'($urandom);
      b = (k % 4 == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      issue(a, b);
      wait_done(n, bs, tmo);
      e = sb.pop_front();
      checks++;
      if (tmo || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dz}) begin
        errors++;
        $display("FAIL rand_%0d %0d/%0d: got q=%0d r=%0d z=%b, want q=%0d r=%0d z=%b",
                 k, a, b, quotient, remainder, div_by_zero, e.q, e.r, e.dz);
      end
      if (b != 16'd0) begin
        checks++;
        if (32'(quotient) * 32'(b) + 32'(remainder) != 32'(a) ||
            remainder >= b) begin
          errors++;
          $display("FAIL rand_invariant_%0d %0d/%0d: got q=%0d r=%0d",
                   k, a, b, quotient, remainder);
        end
      end
      if (k % 2 == 0) @(negedge clk);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    @(negedge clk);
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_basic();
    test_extremes();
    test_div_zero();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
